data_sram_responder: RTL

//  Memory-side responder for the core's data SRAM-like port: answers en/wen/addr/wdata requests with

---
 rtl/data_sram_responder_pkg.sv | 49 ++++
 rtl/data_sram_responder_timer.sv | 80 ++++++++
 rtl/data_sram_responder.sv | 100 ++++++++++
 3 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants, MMIO register map and byte-lane helpers for the data SRAM responder.
package data_sram_responder_pkg;

    localparam int          RAM_AW_DEF    = 14;
    localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;
    localparam logic [31:0] CMP_RESET_DEF = 32'hFFFF_FFFF;

    localparam logic [15:0] LED_OFS  = 16'hF000;
    localparam logic [15:0] SW_OFS   = 16'hF004;
    localparam logic [15:0] CNT_OFS  = 16'hF008;
    localparam logic [15:0] CMP_OFS  = 16'hF00C;
    localparam logic [15:0] CTRL_OFS = 16'hF010;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_PEND_BIT = 1;

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_LED  = 3'd1,
        REG_SW   = 3'd2,
        REG_CNT  = 3'd3,
        REG_CMP  = 3'd4,
        REG_CTRL = 3'd5
    } mmio_reg_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    function automatic mmio_reg_e decode_ofs(input logic [15:0] ofs);
        mmio_reg_e sel;
        case (ofs)
            LED_OFS:  sel = REG_LED;
            SW_OFS:   sel = REG_SW;
            CNT_OFS:  sel = REG_CNT;
            CMP_OFS:  sel = REG_CMP;
            CTRL_OFS: sel = REG_CTRL;
            default:  sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/data_sram_responder_timer.sv
// Timer block: free-running counter, compare register, enable/pending control and interrupt.
module data_sram_responder_timer
    import data_sram_responder_pkg::*;
#(
    parameter logic [31:0] CMP_RESET = CMP_RESET_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cnt_we_i,
    input  logic        cmp_we_i,
    input  logic        ctrl_we_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        enable_q, enable_d;
    logic        pending_q, pending_d;
    logic        set_s, clr_s;

    // Next-state: software writes beat the increment; a match beats write-1-clear.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        enable_d  = enable_q;
        pending_d = pending_q;
        set_s     = enable_q && (count_q == compare_q);
        clr_s     = ctrl_we_i && wen_i[0] && wdata_i[CTRL_PEND_BIT];
        if (cnt_we_i) begin
            count_d = merge_lanes(count_q, wdata_i, wen_i);
        end else if (enable_q) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
        if (cmp_we_i) begin
            compare_d = merge_lanes(compare_q, wdata_i, wen_i);
        end else begin
            compare_d = compare_q;
        end
        if (ctrl_we_i && wen_i[0]) begin
            enable_d = wdata_i[CTRL_EN_BIT];
        end else begin
            enable_d = enable_q;
        end
        if (set_s) begin
            pending_d = 1'b1;
        end else if (clr_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q   <= 32'h0000_0000;
            compare_q <= CMP_RESET;
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ctrl_o    = {30'h0, pending_q, enable_q};
    assign irq_o     = pending_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM plus LED/switch/timer MMIO window, 1-cycle registered rdata.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AW    = RAM_AW_DEF,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] CMP_RESET = CMP_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic        timer_int
);

    logic [31:0]       mem_q [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] idx_s;
    logic              is_mmio_s;
    logic              wr_s;
    mmio_reg_e         reg_sel_s;
    logic [31:0]       mmio_rd_s;
    logic [31:0]       count_s, compare_s, ctrl_s;
    logic [15:0]       led_q, led_d;
    logic [15:0]       sw_q;
    logic [31:0]       rdata_q;

    assign idx_s     = data_sram_addr[RAM_AW+1:2];
    assign is_mmio_s = (data_sram_addr[31:16] == MMIO_BASE);
    assign wr_s      = data_sram_en && (data_sram_wen != 4'b0000);
    assign reg_sel_s = is_mmio_s ? decode_ofs(data_sram_addr[15:0]) : REG_NONE;

    // LED lane merge and MMIO read mux.
    always_comb begin
        led_d     = led_q;
        mmio_rd_s = 32'h0000_0000;
        if (wr_s && (reg_sel_s == REG_LED)) begin
            led_d[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0];
            led_d[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8];
        end else begin
            led_d = led_q;
        end
        case (reg_sel_s)
            REG_LED:  mmio_rd_s = {16'h0000, led_q};
            REG_SW:   mmio_rd_s = {16'h0000, sw_q};
            REG_CNT:  mmio_rd_s = count_s;
            REG_CMP:  mmio_rd_s = compare_s;
            REG_CTRL: mmio_rd_s = ctrl_s;
            default:  mmio_rd_s = 32'h0000_0000;
        endcase
    end

    // RAM write port: not reset, so writes in a reset cycle still land.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_s && !is_mmio_s && data_sram_wen[i]) begin
                mem_q[idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Response and MMIO registers; RAM read is read-first against the write above.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0000_0000;
            led_q   <= 16'h0000;
            sw_q    <= 16'h0000;
        end else begin
            led_q <= led_d;
            sw_q  <= switch_in;
            if (data_sram_en) begin
                rdata_q <= is_mmio_s ? mmio_rd_s : mem_q[idx_s];
            end
        end
    end

    data_sram_responder_timer #(
        .CMP_RESET (CMP_RESET)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .cnt_we_i  (wr_s && (reg_sel_s == REG_CNT)),
        .cmp_we_i  (wr_s && (reg_sel_s == REG_CMP)),
        .ctrl_we_i (wr_s && (reg_sel_s == REG_CTRL)),
        .wen_i     (data_sram_wen),
        .wdata_i   (data_sram_wdata),
        .count_o   (count_s),
        .compare_o (compare_s),
        .ctrl_o    (ctrl_s),
        .irq_o     (timer_int)
    );

    assign data_sram_rdata = rdata_q;
    assign led_out         = led_q;

endmodule
